ram_n: RTL

- Parametrised successor to the fixed 8x16 register-file RAM used by the Hack-style memory hierarchy. Width and depth are generic.
- Writes are clocked on the single system clock instead of being edge-triggered on the load strobe.
- Reads stay combinational, so it is a drop-in for existing CPU/memory glue.
- Adds a hardware zero-fill sequencer that runs after reset and on a clear request, so contents are always defined.

---
 rtl/ram_n.sv | 100 ++++++++++
 1 files changed

// File: rtl/ram_n.sv
// ram_n: parametrised register-file RAM with a hardware zero-fill sequencer.
//
// Writes are clocked on clk. Reads are combinational from address. After reset,
// and whenever clear is requested while idle, every word is written to zero, one
// word per cycle. While that fill runs, busy is high, out reads as zero, and
// load/clear are ignored.
//
// Ports:
//   clk      in   1           system clock, rising-edge active
//   reset    in   1           synchronous, active-high; restarts the zero-fill
//   clear    in   1           request a zero-fill of the whole array (idle only)
//   address  in   ADDR_WIDTH  read and write word select
//   in       in   WIDTH       write data
//   load     in   1           write enable (idle only; clear takes priority)
//   out      out  WIDTH       read data, combinational; zero while busy
//   busy     out  1           zero-fill in progress (decoded from state register)
module ram_n #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [WIDTH-1:0]      in,
    input  logic                  load,
    output logic [WIDTH-1:0]      out,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fptr_q, fptr_d;

    logic                    we;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [WIDTH-1:0]        wdata;

    logic [WIDTH-1:0]        mem_q [DEPTH];

    // Next-state and write-port selection. The fill owns the write port while
    // active, which is what makes load and clear ineffective during FILL.
    always_comb begin
        state_d = state_q;
        fptr_d  = fptr_q;
        we      = 1'b0;
        waddr   = address;
        wdata   = in;
        unique case (state_q)
            FILL: begin
                we    = 1'b1;
                waddr = fptr_q;
                wdata = '0;
                // All-ones pointer is the last word because DEPTH is a power of two.
                if (&fptr_q) begin
                    state_d = IDLE;
                    fptr_d  = '0;
                end else begin
                    fptr_d = fptr_q + 1'b1;
                end
            end
            default: begin
                if (clear) begin
                    // A simultaneous load is dropped.
                    state_d = FILL;
                    fptr_d  = '0;
                end else if (load) begin
                    we = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            fptr_q  <= '0;
        end else begin
            state_q <= state_d;
            fptr_q  <= fptr_d;
        end
    end

    // The array is not reset directly; the zero-fill defines its contents.
    always_ff @(posedge clk) begin
        if (!reset && we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign busy = (state_q == FILL);
    assign out  = busy ? '0 : mem_q[address];

endmodule
